// File: rtl/development_milestone_tracker.sv
// Debounces the raw development stage into committed transitions, with
// up/down event pulses, a high-water mark, a regression flag and a saturating age.
module development_milestone_tracker #(
  parameter int unsigned HOLD_CYCLES = 4,
  parameter int unsigned AGE_W       = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       development_stage,
  output logic [1:0]       committed_stage,
  output logic [1:0]       max_stage,
  output logic             stage_up,
  output logic             stage_down,
  output logic             regressed,
  output logic [AGE_W-1:0] stage_age
);

  localparam int unsigned      CNT_W    = $clog2(HOLD_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [AGE_W-1:0] AGE_MAX  = '1;
  localparam bit               IMMEDIATE = (HOLD_CYCLES == 1);

  typedef enum logic {
    STABLE,
    PENDING
  } state_t;

  state_t           state;
  logic [1:0]       candidate;
  logic [CNT_W-1:0] hold_cnt;
  logic             commit;
  logic [1:0]       commit_val;

  // Decide whether this edge commits, and which value it commits.
  always_comb begin
    commit     = 1'b0;
    commit_val = committed_stage;
    case (state)
      STABLE: begin
        if (IMMEDIATE && (development_stage != committed_stage)) begin
          commit     = 1'b1;
          commit_val = development_stage;
        end
      end
      PENDING: begin
        if ((development_stage == candidate) && (hold_cnt == CNT_LAST)) begin
          commit     = 1'b1;
          commit_val = candidate;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= STABLE;
      candidate       <= 2'd0;
      hold_cnt        <= '0;
      committed_stage <= 2'd0;
      max_stage       <= 2'd0;
      stage_up        <= 1'b0;
      stage_down      <= 1'b0;
      stage_age       <= '0;
    end else begin
      stage_up   <= 1'b0;
      stage_down <= 1'b0;

      if (commit) begin
        committed_stage <= commit_val;
        if (commit_val > max_stage) max_stage <= commit_val;
        stage_age  <= '0;
        stage_up   <= (commit_val > committed_stage);
        stage_down <= (commit_val < committed_stage);
      end else if (stage_age != AGE_MAX) begin
        stage_age <= stage_age + 1'b1;
      end

      case (state)
        STABLE: begin
          if (!IMMEDIATE && (development_stage != committed_stage)) begin
            state     <= PENDING;
            candidate <= development_stage;
            hold_cnt  <= CNT_ONE;
          end else begin
            hold_cnt <= '0;
          end
        end
        PENDING: begin
          if (development_stage == candidate) begin
            if (hold_cnt == CNT_LAST) begin
              state    <= STABLE;
              hold_cnt <= '0;
            end else begin
              hold_cnt <= hold_cnt + 1'b1;
            end
          end else if (development_stage == committed_stage) begin
            state    <= STABLE;
            hold_cnt <= '0;
          end else begin
            // A third value restarts the debounce rather than aborting it.
            candidate <= development_stage;
            hold_cnt  <= CNT_ONE;
          end
        end
        default: begin
          state    <= STABLE;
          hold_cnt <= '0;
        end
      endcase
    end
  end

  assign regressed = (committed_stage < max_stage);

endmodule

// File: tb/tb_development_milestone_tracker.sv
// Scoreboarded bench: expected commit events are queued by the stimulus and
// consumed by a monitor whenever the tracker emits an up/down pulse.
module tb_development_milestone_tracker;

  logic        clk;
  logic        rst_n;
  logic [1:0]  stage_in;

  logic [1:0]  committed_stage, max_stage;
  logic        stage_up, stage_down, regressed;
  logic [11:0] stage_age;

  logic [1:0]  f_committed, f_max;
  logic        f_up, f_down, f_regressed;
  logic [2:0]  f_age;

  int tests_run;
  int tests_failed;

  typedef struct packed {
    logic [1:0] committed;
    logic [1:0] max;
    logic       up;
    logic       down;
    logic       reg_flag;
  } event_t;

  event_t exp_q[$];

  development_milestone_tracker #(.HOLD_CYCLES(4), .AGE_W(12)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .development_stage(stage_in),
    .committed_stage  (committed_stage),
    .max_stage        (max_stage),
    .stage_up         (stage_up),
    .stage_down       (stage_down),
    .regressed        (regressed),
    .stage_age        (stage_age)
  );

  // Second instance: immediate commits and a tiny age counter.
  development_milestone_tracker #(.HOLD_CYCLES(1), .AGE_W(3)) dut_fast (
    .clk              (clk),
    .rst_n            (rst_n),
    .development_stage(stage_in),
    .committed_stage  (f_committed),
    .max_stage        (f_max),
    .stage_up         (f_up),
    .stage_down       (f_down),
    .regressed        (f_regressed),
    .stage_age        (f_age)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic applyStimulus(input logic [1:0] v, input int n);
    for (int i = 0; i < n; i++) begin
      stage_in = v;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic checkOutput(input string name, input logic [15:0] actual,
                             input logic [15:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic expectEvent(input logic [1:0] c, input logic [1:0] m,
                             input logic up, input logic down, input logic rg);
    event_t e;
    e.committed = c;
    e.max       = m;
    e.up        = up;
    e.down      = down;
    e.reg_flag  = rg;
    exp_q.push_back(e);
  endtask

  // Every pulse must match the oldest outstanding expected commit.
  always @(negedge clk) begin
    if (rst_n && (stage_up || stage_down)) begin
      event_t got;
      event_t want;
      got.committed = committed_stage;
      got.max       = max_stage;
      got.up        = stage_up;
      got.down      = stage_down;
      got.reg_flag  = regressed;
      tests_run++;
      if (exp_q.size() == 0) begin
        tests_failed++;
        $display("[TB] FAIL unexpected_commit: got %0h, expected no event", got);
      end else begin
        want = exp_q.pop_front();
        if (got !== want) begin
          tests_failed++;
          $display("[TB] FAIL commit_event: got %0h, expected %0h", got, want);
        end
      end
    end
  end

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    stage_in     = 2'd0;
    rst_n        = 1'b0;
    #1;
    checkOutput("reset_committed", 16'(committed_stage), 16'd0);
    checkOutput("reset_max", 16'(max_stage), 16'd0);
    checkOutput("reset_pulses", 16'({stage_up, stage_down, regressed}), 16'd0);
    checkOutput("reset_age", 16'(stage_age), 16'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Stable input: only the age moves.
    applyStimulus(2'd0, 20);
    checkOutput("idle_committed", 16'(committed_stage), 16'd0);
    checkOutput("idle_regressed", 16'(regressed), 16'd0);
    checkOutput("idle_age", 16'(stage_age), 16'd20);
    checkOutput("fast_age_saturate", 16'(f_age), 16'd7);

    // 0 -> 1 held: commits on the fourth edge.
    expectEvent(2'd1, 2'd1, 1'b1, 1'b0, 1'b0);
    applyStimulus(2'd1, 1);
    checkOutput("fast_commit", 16'(f_committed), 16'd1);
    checkOutput("fast_up", 16'(f_up), 16'd1);
    checkOutput("fast_age_reset", 16'(f_age), 16'd0);
    applyStimulus(2'd1, 2);
    checkOutput("hold3_committed", 16'(committed_stage), 16'd0);
    checkOutput("fast_up_cleared", 16'(f_up), 16'd0);
    applyStimulus(2'd1, 1);
    checkOutput("hold4_committed", 16'(committed_stage), 16'd1);
    checkOutput("hold4_up", 16'(stage_up), 16'd1);
    checkOutput("hold4_age", 16'(stage_age), 16'd0);
    applyStimulus(2'd1, 1);
    checkOutput("up_one_cycle", 16'(stage_up), 16'd0);
    checkOutput("age_after_commit", 16'(stage_age), 16'd1);

    // Short glitch then back to the committed value: no commit.
    applyStimulus(2'd2, 3);
    applyStimulus(2'd1, 2);
    checkOutput("glitch_committed", 16'(committed_stage), 16'd1);
    checkOutput("glitch_max", 16'(max_stage), 16'd1);
    checkOutput("glitch_age", 16'(stage_age), 16'd6);

    // Candidate changes mid-debounce: restart, single commit to 2.
    expectEvent(2'd2, 2'd2, 1'b1, 1'b0, 1'b0);
    applyStimulus(2'd3, 2);
    applyStimulus(2'd2, 3);
    checkOutput("restart_not_yet", 16'(committed_stage), 16'd1);
    applyStimulus(2'd2, 1);
    checkOutput("restart_committed", 16'(committed_stage), 16'd2);
    checkOutput("restart_max", 16'(max_stage), 16'd2);

    // Up to 3, then a two-stage drop to 1.
    expectEvent(2'd3, 2'd3, 1'b1, 1'b0, 1'b0);
    applyStimulus(2'd3, 4);
    checkOutput("to3_committed", 16'(committed_stage), 16'd3);
    expectEvent(2'd1, 2'd3, 1'b0, 1'b1, 1'b1);
    applyStimulus(2'd1, 4);
    checkOutput("drop_committed", 16'(committed_stage), 16'd1);
    checkOutput("drop_down", 16'(stage_down), 16'd1);
    checkOutput("drop_max", 16'(max_stage), 16'd3);
    checkOutput("drop_regressed", 16'(regressed), 16'd1);
    applyStimulus(2'd1, 1);
    checkOutput("down_one_cycle", 16'(stage_down), 16'd0);

    // Reset while a candidate is pending.
    applyStimulus(2'd2, 2);
    #3;
    rst_n = 1'b0;
    #1;
    checkOutput("midreset_committed", 16'(committed_stage), 16'd0);
    checkOutput("midreset_max", 16'(max_stage), 16'd0);
    checkOutput("midreset_age", 16'(stage_age), 16'd0);
    checkOutput("midreset_flags", 16'({stage_up, stage_down, regressed}), 16'd0);
    checkOutput("midreset_fast", 16'({f_committed, f_max, f_age}), 16'd0);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(2'd2, 3);
    checkOutput("postreset_no_commit", 16'(committed_stage), 16'd0);
    expectEvent(2'd2, 2'd2, 1'b1, 1'b0, 1'b0);
    applyStimulus(2'd2, 1);
    checkOutput("postreset_commit", 16'(committed_stage), 16'd2);
    applyStimulus(2'd2, 2);

    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("[TB] FAIL missing_events: got %0d outstanding, expected 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
